// File: rtl/cpu_dbg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_dbg_pkg
//  Description : Shared definitions for the CPU debug dump stream: beat tag
//                codes, dumper FSM state encoding and default widths. Also
//                used by the debug bridge that decodes the beat stream.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_dbg_pkg;

    // Default geometry of the dumped state
    localparam int DEF_DATA_W    = 32;
    localparam int DEF_NREG      = 8;
    localparam int DEF_MEM_WORDS = 8;
    localparam int DEF_MEM_AW    = 10;

    // Beat tags carried on out_tag
    localparam logic [1:0] TAG_PC  = 2'd0;
    localparam logic [1:0] TAG_REG = 2'd1;
    localparam logic [1:0] TAG_MEM = 2'd2;
    localparam logic [1:0] TAG_END = 2'd3;

    // Dumper FSM state encoding
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_PC        = 3'd1;
    localparam logic [2:0] ST_REG       = 3'd2;
    localparam logic [2:0] ST_MEM_ISSUE = 3'd3;
    localparam logic [2:0] ST_MEM_CAP   = 3'd4;
    localparam logic [2:0] ST_END       = 3'd5;

endpackage : cpu_dbg_pkg
`default_nettype wire

// File: rtl/dump_beat_reg.sv
`default_nettype none
// ============================================================================
//  Module      : dump_beat_reg
//  Description : Single-entry valid/ready holding register for one tagged
//                beat. A load captures tag/idx/data and raises valid; the
//                entry is cleared on handshake unless reloaded on that edge.
//                Payload never changes while valid is high and ready is low.
//  Revision    : 1.0 - initial release
//  Ports       : clk, rst (async, active-low)
//                load, ld_tag, ld_idx, ld_data : new beat from the producer
//                ready                        : sink accepts beat
//                valid, tag, idx, data        : held beat
//                fire                         : valid && ready this cycle
// ============================================================================
module dump_beat_reg #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [1:0]        ld_tag,
    input  logic [7:0]        ld_idx,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ready,
    output logic              valid,
    output logic [1:0]        tag,
    output logic [7:0]        idx,
    output logic [DATA_W-1:0] data,
    output logic              fire
);

    logic              r_valid;
    logic [1:0]        r_tag;
    logic [7:0]        r_idx;
    logic [DATA_W-1:0] r_data;

    assign fire  = r_valid && ready;
    assign valid = r_valid;
    assign tag   = r_tag;
    assign idx   = r_idx;
    assign data  = r_data;

    // The producer only loads when the entry is empty or firing, so a load
    // always takes priority over the handshake clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_tag   <= 2'd0;
            r_idx   <= 8'd0;
            r_data  <= '0;
        end else if (load) begin
            r_valid <= 1'b1;
            r_tag   <= ld_tag;
            r_idx   <= ld_idx;
            r_data  <= ld_data;
        end else if (fire) begin
            r_valid <= 1'b0;
            r_tag   <= 2'd0;
            r_idx   <= 8'd0;
            r_data  <= '0;
        end
    end

endmodule : dump_beat_reg
`default_nettype wire

// File: rtl/cpu_state_dumper.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_state_dumper
//  Description : Streams halted-CPU state (PC, R0..R(NREG-1), data memory
//                words 0..MEM_WORDS-1) as tagged beats on a valid/ready
//                port, terminated by an END beat. Dropping halted mid-dump
//                aborts: the pending beat completes, then END with idx[0]=1.
//  Options     : DUMP_CHECKSUM_EN - END payload carries the XOR of all
//                handshaken PC/REG/MEM payloads (else END payload is 0).
//  Revision    : 1.0 - initial release
//  Ports       : clk, rst (async, active-low)
//                halted, dump_req, pc        : CPU side status / request
//                rf_addr -> rf_data          : register-file read port
//                mem_rd, mem_addr -> mem_data: data-memory read (1-cycle lat)
//                out_valid/ready/tag/idx/data: beat stream
//                busy, done                  : dump in progress / END accepted
// ============================================================================
module cpu_state_dumper
    import cpu_dbg_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int NREG      = DEF_NREG,
    parameter int MEM_WORDS = DEF_MEM_WORDS,
    parameter int MEM_AW    = DEF_MEM_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              halted,
    input  logic              dump_req,
    input  logic [DATA_W-1:0] pc,
    output logic [2:0]        rf_addr,
    input  logic [DATA_W-1:0] rf_data,
    output logic              mem_rd,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        out_tag,
    output logic [7:0]        out_idx,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done
);

    localparam logic [7:0] C_NREG      = 8'(NREG);
    localparam logic [7:0] C_MEM_WORDS = 8'(MEM_WORDS);

    logic [2:0]        r_state;
    logic [7:0]        r_cnt;
    logic              r_busy;
    logic              r_done;
    logic              r_aborted;

    logic              w_fire;
    logic              w_free;
    logic              w_abort;
    logic              w_start;
    logic              w_end_held;
    logic              w_ld;
    logic [1:0]        w_ld_tag;
    logic [7:0]        w_ld_idx;
    logic [DATA_W-1:0] w_ld_data;
    logic [DATA_W-1:0] w_end_data;
    logic              w_mem_rd;

    // Beat slot can take a new beat this edge: empty, or current beat firing.
    assign w_free     = !out_valid || w_fire;
    // Abort seen now or earlier in this dump; sticky so halted re-rising
    // cannot resume the dump.
    assign w_abort    = r_aborted || !halted;
    assign w_start    = (r_state == ST_IDLE) && dump_req && halted;
    assign w_end_held = out_valid && (out_tag == TAG_END);

    assign rf_addr  = r_cnt[2:0];
    assign mem_addr = MEM_AW'(r_cnt);
    assign mem_rd   = w_mem_rd;
    assign busy     = r_busy;
    assign done     = r_done;

`ifdef DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] r_csum;
    logic [DATA_W-1:0] w_csum_next;

    // Fold in the beat firing this edge so an END loaded on the same edge
    // as the last data beat still covers it.
    assign w_csum_next = r_csum ^ ((w_fire && (out_tag != TAG_END)) ? out_data : '0);
    assign w_end_data  = w_csum_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_csum <= '0;
        end else if (w_start) begin
            r_csum <= '0;
        end else begin
            r_csum <= w_csum_next;
        end
    end
`else
    assign w_end_data = '0;
`endif

    // Beat-slot load selection and memory read strobe.
    always_comb begin
        w_ld      = 1'b0;
        w_ld_tag  = TAG_PC;
        w_ld_idx  = 8'd0;
        w_ld_data = '0;
        w_mem_rd  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_ld      = 1'b1;
                    w_ld_tag  = TAG_PC;
                    w_ld_data = pc;
                end
            end
            // PC and REG share one rule: r_cnt is the next register to send,
            // so register 0 loads as the PC beat fires (back-to-back).
            ST_PC, ST_REG: begin
                if (w_free && !w_abort && (r_cnt < C_NREG)) begin
                    w_ld      = 1'b1;
                    w_ld_tag  = TAG_REG;
                    w_ld_idx  = r_cnt;
                    w_ld_data = rf_data;
                end
            end
            // A read is only issued when the slot will be empty next cycle,
            // so the captured word always has somewhere to go.
            ST_MEM_ISSUE: begin
                w_mem_rd = w_free && !w_abort;
            end
            ST_MEM_CAP: begin
                w_ld      = 1'b1;
                w_ld_tag  = TAG_MEM;
                w_ld_idx  = r_cnt;
                w_ld_data = mem_data;
            end
            ST_END: begin
                if (w_free && !w_end_held) begin
                    w_ld      = 1'b1;
                    w_ld_tag  = TAG_END;
                    w_ld_idx  = {7'd0, w_abort};
                    w_ld_data = w_end_data;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 8'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_busy && !halted) begin
                r_aborted <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state   <= ST_PC;
                        r_busy    <= 1'b1;
                        r_cnt     <= 8'd0;
                        r_aborted <= 1'b0;
                    end
                end
                ST_PC, ST_REG: begin
                    if (w_free) begin
                        if (w_abort) begin
                            r_state <= ST_END;
                        end else if (r_cnt < C_NREG) begin
                            r_cnt   <= r_cnt + 8'd1;
                            r_state <= ST_REG;
                        end else if (C_MEM_WORDS != 8'd0) begin
                            r_cnt   <= 8'd0;
                            r_state <= ST_MEM_ISSUE;
                        end else begin
                            r_state <= ST_END;
                        end
                    end
                end
                ST_MEM_ISSUE: begin
                    if (w_free) begin
                        r_state <= w_abort ? ST_END : ST_MEM_CAP;
                    end
                end
                // A read already issued is still delivered; the abort is
                // taken at the next issue point instead.
                ST_MEM_CAP: begin
                    if ((r_cnt + 8'd1) < C_MEM_WORDS) begin
                        r_cnt   <= r_cnt + 8'd1;
                        r_state <= ST_MEM_ISSUE;
                    end else begin
                        r_state <= ST_END;
                    end
                end
                ST_END: begin
                    if (w_end_held && out_ready) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    dump_beat_reg #(
        .DATA_W (DATA_W)
    ) u_beat (
        .clk     (clk),
        .rst     (rst),
        .load    (w_ld),
        .ld_tag  (w_ld_tag),
        .ld_idx  (w_ld_idx),
        .ld_data (w_ld_data),
        .ready   (out_ready),
        .valid   (out_valid),
        .tag     (out_tag),
        .idx     (out_idx),
        .data    (out_data),
        .fire    (w_fire)
    );

endmodule : cpu_state_dumper
`default_nettype wire
